// File: rtl/sd_resp_pkg.sv
// Shared types and constants for the SD sector responder: FSM state encoding
// and sector geometry.
package sd_resp_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int OFS_W        = 9;
    localparam logic [OFS_W-1:0] OFS_LAST = OFS_W'(SECTOR_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        RD_REQ  = 3'd2,
        RD_PUT  = 3'd3,
        WR_ADDR = 3'd4,
        WR_LAT  = 3'd5,
        WR_REQ  = 3'd6,
        DONE    = 3'd7
    } state_t;

endpackage

// File: rtl/sd_sector_responder_if.sv
// Backing-store bus between the sector responder (master) and the image
// storage (slave); one mem_ack pulse completes one byte.
interface sd_sector_responder_if;
    import sd_resp_pkg::*;

    logic             mem_req;
    logic             mem_we;
    logic [1:0]       mem_drv;
    logic [31:0]      mem_lba;
    logic [OFS_W-1:0] mem_ofs;
    logic [7:0]       mem_wdata;
    logic [7:0]       mem_rdata;
    logic             mem_ack;

    modport master (
        output mem_req, mem_we, mem_drv, mem_lba, mem_ofs, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_drv, mem_lba, mem_ofs, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/sd_resp_arb.sv
// Combinational drive/direction selector: lowest drive index wins, and a read
// beats a write on the same drive.
module sd_resp_arb #(
    parameter int VDNUM = 3
) (
    input  logic [VDNUM-1:0] rd,
    input  logic [VDNUM-1:0] wr,
    output logic             req,
    output logic             is_wr,
    output logic [1:0]       drv,
    output logic [VDNUM-1:0] gnt
);

    logic hit;

    // Scan from the top down so the lowest requesting index is the last to land
    always_comb begin
        req   = 1'b0;
        is_wr = 1'b0;
        drv   = 2'd0;
        gnt   = '0;
        hit   = 1'b0;
        for (int i = VDNUM - 1; i >= 0; i--) begin
            hit   = rd[i] | wr[i];
            req   = req | hit;
            is_wr = hit ? ~rd[i] : is_wr;
            drv   = hit ? 2'(i) : drv;
            gnt   = hit ? (VDNUM'(1'b1) << i) : gnt;
        end
    end

endmodule

// File: rtl/sd_sector_responder.sv
// Serves 512-byte sector reads/writes between the SD buffer and a byte-wide
// backing store. Optional write protection: define SDRESP_WRPROT_EN.
module sd_sector_responder
    import sd_resp_pkg::*;
#(
    parameter int VDNUM = 3
) (
    input  logic                  clk_sys,
    input  logic                  RESET_N,
    input  logic [31:0]           sd_lba,
    input  logic [VDNUM-1:0]      sd_rd,
    input  logic [VDNUM-1:0]      sd_wr,
    output logic                  sd_ack,
    output logic [OFS_W-1:0]      sd_buff_addr,
    output logic [7:0]            sd_buff_dout,
    output logic                  sd_buff_wr,
    input  logic [7:0]            sd_buff_din,
    input  logic [VDNUM-1:0]      img_present,
    input  logic [VDNUM-1:0]      img_readonly,
    sd_sector_responder_if.master mem,
    output logic                  busy,
    output logic                  err
);

`ifdef SDRESP_WRPROT_EN
    localparam logic WRPROT_EN = 1'b1;
`else
    localparam logic WRPROT_EN = 1'b0;
`endif

    state_t           state_r, state_s;
    logic [OFS_W-1:0] ofs_r, ofs_s, addr_r, addr_s;
    logic [31:0]      lba_r, lba_s;
    logic [1:0]       drv_r, drv_s;
    logic             is_wr_r, is_wr_s, nodata_r, nodata_s, last_s;
    logic [7:0]       dout_r, dout_s, wdata_r, wdata_s;
    logic             buff_wr_r, buff_wr_s, req_r, req_s, we_r, we_s;
    logic             ack_r, ack_s, busy_r, busy_s, err_r, err_s;
    logic             arb_req_s, arb_is_wr_s, miss_s, ro_hit_s;
    logic [1:0]       arb_drv_s;
    logic [VDNUM-1:0] arb_gnt_s;

    sd_resp_arb #(.VDNUM(VDNUM)) u_arb (
        .rd    (sd_rd),
        .wr    (sd_wr),
        .req   (arb_req_s),
        .is_wr (arb_is_wr_s),
        .drv   (arb_drv_s),
        .gnt   (arb_gnt_s)
    );

    assign miss_s   = |(arb_gnt_s & ~img_present);
    assign ro_hit_s = |(arb_gnt_s & img_readonly);

    // Next state, datapath updates and next values of the registered outputs
    always_comb begin
        state_s  = state_r;
        ofs_s    = ofs_r;
        addr_s   = addr_r;
        lba_s    = lba_r;
        drv_s    = drv_r;
        is_wr_s  = is_wr_r;
        nodata_s = nodata_r;
        dout_s   = dout_r;
        wdata_s  = wdata_r;
        last_s   = (ofs_r == OFS_LAST);
        case (state_r)
            IDLE: begin
                if (arb_req_s) begin
                    state_s  = GRANT;
                    lba_s    = sd_lba;
                    drv_s    = arb_drv_s;
                    is_wr_s  = arb_is_wr_s;
                    nodata_s = miss_s | (WRPROT_EN & arb_is_wr_s & ro_hit_s);
                    ofs_s    = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                addr_s = ofs_r;
                if (is_wr_r) begin
                    state_s = WR_ADDR;
                end else if (nodata_r) begin
                    state_s = RD_PUT;
                    dout_s  = 8'h00;
                end else begin
                    state_s = RD_REQ;
                end
            end
            RD_REQ: begin
                if (mem.mem_ack) begin
                    state_s = RD_PUT;
                    dout_s  = mem.mem_rdata;
                    addr_s  = ofs_r;
                end else begin
                    state_s = RD_REQ;
                end
            end
            // Offset 511 exits to DONE instead of wrapping back into the loop
            RD_PUT: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    ofs_s  = ofs_r + OFS_W'(1'b1);
                    addr_s = ofs_r + OFS_W'(1'b1);
                    if (nodata_r) begin
                        state_s = RD_PUT;
                        dout_s  = 8'h00;
                    end else begin
                        state_s = RD_REQ;
                    end
                end
            end
            WR_ADDR: state_s = WR_LAT;
            WR_LAT: begin
                wdata_s = sd_buff_din;
                if (!nodata_r) begin
                    state_s = WR_REQ;
                end else if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = WR_ADDR;
                    ofs_s   = ofs_r + OFS_W'(1'b1);
                    addr_s  = ofs_r + OFS_W'(1'b1);
                end
            end
            WR_REQ: begin
                if (!mem.mem_ack) begin
                    state_s = WR_REQ;
                end else if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = WR_ADDR;
                    ofs_s   = ofs_r + OFS_W'(1'b1);
                    addr_s  = ofs_r + OFS_W'(1'b1);
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
        buff_wr_s = (state_s == RD_PUT);
        req_s     = (state_s == RD_REQ) || (state_s == WR_REQ);
        we_s      = (state_s == WR_REQ);
        ack_s     = (state_s != IDLE) && (state_s != GRANT) && (state_s != DONE);
        busy_s    = (state_s != IDLE);
        err_s     = (state_s == DONE) && nodata_r;
    end

    // FSM state register
    always_ff @(posedge clk_sys) begin
        if (!RESET_N) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Transfer context and registered outputs
    always_ff @(posedge clk_sys) begin
        if (!RESET_N) begin
            ofs_r     <= '0;
            addr_r    <= '0;
            lba_r     <= 32'd0;
            drv_r     <= 2'd0;
            is_wr_r   <= 1'b0;
            nodata_r  <= 1'b0;
            dout_r    <= 8'h00;
            wdata_r   <= 8'h00;
            buff_wr_r <= 1'b0;
            req_r     <= 1'b0;
            we_r      <= 1'b0;
            ack_r     <= 1'b0;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            ofs_r     <= ofs_s;
            addr_r    <= addr_s;
            lba_r     <= lba_s;
            drv_r     <= drv_s;
            is_wr_r   <= is_wr_s;
            nodata_r  <= nodata_s;
            dout_r    <= dout_s;
            wdata_r   <= wdata_s;
            buff_wr_r <= buff_wr_s;
            req_r     <= req_s;
            we_r      <= we_s;
            ack_r     <= ack_s;
            busy_r    <= busy_s;
            err_r     <= err_s;
        end
    end

    assign sd_ack        = ack_r;
    assign sd_buff_addr  = addr_r;
    assign sd_buff_dout  = dout_r;
    assign sd_buff_wr    = buff_wr_r;
    assign busy          = busy_r;
    assign err           = err_r;
    assign mem.mem_req   = req_r;
    assign mem.mem_we    = we_r;
    assign mem.mem_drv   = drv_r;
    assign mem.mem_lba   = lba_r;
    assign mem.mem_ofs   = ofs_r;
    assign mem.mem_wdata = wdata_r;

endmodule

// File: tb/tb_sd_sector_responder.sv
// Scoreboard bench for sd_sector_responder: expected buffer and memory writes
// are queued at stimulus time and checked by an independent monitor.
module tb_sd_sector_responder;

    localparam int VDNUM = 3;

    typedef struct packed {logic [8:0] a; logic [7:0] d;} bexp_t;
    typedef struct packed {logic [1:0] drv; logic [31:0] lba; logic [8:0] ofs; logic [7:0] d;} mexp_t;

    logic        clk_sys = 1'b0;
    logic        RESET_N;
    logic [31:0] sd_lba;
    logic [2:0]  sd_rd, sd_wr, img_present, img_readonly;
    logic        sd_ack, sd_buff_wr, busy, err;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout, sd_buff_din;

    sd_sector_responder_if mem();

    sd_sector_responder #(.VDNUM(VDNUM)) dut (
        .clk_sys      (clk_sys),
        .RESET_N      (RESET_N),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .img_present  (img_present),
        .img_readonly (img_readonly),
        .mem          (mem),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk_sys = ~clk_sys;

    int          n_vec, n_bad, err_cnt, req_cnt, fall_cnt, lat_cnt, cyc;
    bit          noise, lat_mode, ack_prev;
    logic [31:0] exp_lba;
    logic [1:0]  exp_drv;
    logic        exp_we;
    logic [7:0]  tbuf [0:511];
    bexp_t       exp_buf[$];
    mexp_t       exp_mw[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Backing store: optional per-offset latency, stray acks while idle
    always @(posedge clk_sys) begin : mem_model
        int want;
        cyc++;
        #2;
        want = lat_mode ? int'(mem.mem_ofs % 9'd3) : 0;
        if (mem.mem_req === 1'b1) begin
            if (lat_cnt >= want) begin
                mem.mem_ack = 1'b1;
                lat_cnt = 0;
            end else begin
                mem.mem_ack = 1'b0;
                lat_cnt++;
            end
        end else begin
            mem.mem_ack = noise & cyc[0];
            lat_cnt = 0;
        end
        mem.mem_rdata = mem.mem_ofs[7:0] ^ {6'd0, mem.mem_drv};
    end

    // SD buffer RAM with one cycle of read latency
    always @(posedge clk_sys) begin : buf_model
        logic [8:0] a;
        a = sd_buff_addr;
        #1;
        sd_buff_din = tbuf[a];
    end

    always @(negedge clk_sys) begin : monitor
        bexp_t b;
        mexp_t m;
        if (sd_buff_wr === 1'b1) begin
            if (exp_buf.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL buf_extra: got write addr %0d data %h, required none", sd_buff_addr, sd_buff_dout);
            end else begin
                b = exp_buf.pop_front();
                check("buf_addr", 64'(sd_buff_addr), 64'(b.a));
                check("buf_data", 64'(sd_buff_dout), 64'(b.d));
            end
        end
        if (mem.mem_req === 1'b1 && mem.mem_we === 1'b1 && mem.mem_ack === 1'b1) begin
            if (exp_mw.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL mem_extra: got write ofs %0d data %h, required none", mem.mem_ofs, mem.mem_wdata);
            end else begin
                m = exp_mw.pop_front();
                check("mem_write", 64'({mem.mem_drv, mem.mem_lba, mem.mem_ofs, mem.mem_wdata}), 64'(m));
            end
        end
        if (mem.mem_req === 1'b1)
            check("mem_attr", 64'({mem.mem_we, mem.mem_drv, mem.mem_lba}), 64'({exp_we, exp_drv, exp_lba}));
        req_cnt += (mem.mem_req === 1'b1) ? 1 : 0;
        err_cnt += (err === 1'b1) ? 1 : 0;
        if (ack_prev && sd_ack === 1'b0) fall_cnt++;
        ack_prev = (sd_ack === 1'b1);
    end

    task automatic wait_ack(input logic lvl, output int n);
        n = 0;
        while (sd_ack !== lvl && n < 6000) begin
            @(negedge clk_sys);
            n++;
        end
        check("ack_wait", 64'(sd_ack), 64'(lvl));
    endtask

    task automatic run_req(input logic [2:0] rd, input logic [2:0] wr, input logic [31:0] lba, output int dur);
        int n;
        err_cnt = 0;
        req_cnt = 0;
        fall_cnt = 0;
        @(negedge clk_sys);
        sd_lba = lba;
        sd_rd = rd;
        sd_wr = wr;
        wait_ack(1'b1, n);
        sd_rd = 3'b000;
        sd_wr = 3'b000;
        sd_lba = ~lba;
        wait_ack(1'b0, dur);
        repeat (4) @(negedge clk_sys);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dur, n, r0;
        n_vec = 0; n_bad = 0; err_cnt = 0; req_cnt = 0; fall_cnt = 0; lat_cnt = 0; cyc = 0;
        noise = 1'b0; lat_mode = 1'b0; ack_prev = 1'b0;
        RESET_N = 1'b0; sd_lba = 32'd0; sd_rd = 3'b000; sd_wr = 3'b000;
        img_present = 3'b111; img_readonly = 3'b000;
        mem.mem_ack = 1'b0; mem.mem_rdata = 8'h00; sd_buff_din = 8'h00;
        exp_lba = 32'd0; exp_drv = 2'd0; exp_we = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("rst_ctl", 64'({sd_ack, sd_buff_wr, mem.mem_req, mem.mem_we, busy, err}), 64'd0);
        check("rst_addr", 64'({sd_buff_addr, mem.mem_ofs, mem.mem_drv}), 64'd0);
        check("rst_lba", 64'(mem.mem_lba), 64'd0);
        check("rst_data", 64'({sd_buff_dout, mem.mem_wdata}), 64'd0);
        RESET_N = 1'b1;
        repeat (2) @(negedge clk_sys);

        // Read drive 0, stray acks and variable latency
        noise = 1'b1; lat_mode = 1'b1;
        exp_lba = 32'h10; exp_drv = 2'd0; exp_we = 1'b0;
        for (int i = 0; i < 512; i++) exp_buf.push_back({9'(i), 8'(i)});
        run_req(3'b001, 3'b000, 32'h10, dur);
        check("rd_done", 64'(exp_buf.size()), 64'd0);
        check("rd_falls", 64'(fall_cnt), 64'd1);
        check("rd_err", 64'(err_cnt), 64'd0);

        // Write drive 1 from a buffer full of 0xA5
        for (int i = 0; i < 512; i++) tbuf[i] = 8'hA5;
        exp_lba = 32'h22; exp_drv = 2'd1; exp_we = 1'b1;
        for (int i = 0; i < 512; i++) exp_mw.push_back({2'd1, 32'h22, 9'(i), 8'hA5});
        run_req(3'b000, 3'b010, 32'h22, dur);
        check("wr_done", 64'(exp_mw.size()), 64'd0);
        check("wr_err", 64'(err_cnt), 64'd0);

        // Write drive 2 with a distinct pattern, zero-latency acks
        noise = 1'b0; lat_mode = 1'b0;
        for (int i = 0; i < 512; i++) tbuf[i] = 8'(i * 7 + 3);
        exp_lba = 32'hDEADBEEF; exp_drv = 2'd2;
        for (int i = 0; i < 512; i++) exp_mw.push_back({2'd2, 32'hDEADBEEF, 9'(i), 8'(i * 7 + 3)});
        run_req(3'b000, 3'b100, 32'hDEADBEEF, dur);
        check("wr2_done", 64'(exp_mw.size()), 64'd0);

        // Simultaneous reads on drives 0 and 2
        exp_lba = 32'h300; exp_drv = 2'd0; exp_we = 1'b0; err_cnt = 0;
        for (int i = 0; i < 512; i++) exp_buf.push_back({9'(i), 8'(i)});
        for (int i = 0; i < 512; i++) exp_buf.push_back({9'(i), 8'(i) ^ 8'h02});
        @(negedge clk_sys);
        sd_lba = 32'h300;
        sd_rd = 3'b101;
        wait_ack(1'b1, n);
        sd_rd = 3'b100;
        wait_ack(1'b0, n);
        exp_drv = 2'd2;
        wait_ack(1'b1, n);
        check("grant_gap", 64'(n), 64'd3);
        sd_rd = 3'b000;
        wait_ack(1'b0, n);
        repeat (4) @(negedge clk_sys);
        check("pri_done", 64'(exp_buf.size()), 64'd0);
        check("pri_err", 64'(err_cnt), 64'd0);

        // Read with no image mounted
        img_present = 3'b000;
        for (int i = 0; i < 512; i++) exp_buf.push_back({9'(i), 8'h00});
        run_req(3'b001, 3'b000, 32'h40, dur);
        check("np_rd_done", 64'(exp_buf.size()), 64'd0);
        check("np_rd_req", 64'(req_cnt), 64'd0);
        check("np_rd_err", 64'(err_cnt), 64'd1);
        check("np_rd_len", 64'(dur), 64'd512);

        // Write with no image mounted on drive 0
        img_present = 3'b110;
        run_req(3'b000, 3'b001, 32'h41, dur);
        check("np_wr_req", 64'(req_cnt), 64'd0);
        check("np_wr_err", 64'(err_cnt), 64'd1);
        check("np_wr_len", 64'(dur), 64'd1024);

        // Write to a read-only image
        img_present = 3'b111; img_readonly = 3'b001;
        for (int i = 0; i < 512; i++) tbuf[i] = 8'(i) ^ 8'h3C;
        exp_lba = 32'h77; exp_drv = 2'd0; exp_we = 1'b1;
`ifdef SDRESP_WRPROT_EN
        run_req(3'b000, 3'b001, 32'h77, dur);
        check("ro_req", 64'(req_cnt), 64'd0);
        check("ro_err", 64'(err_cnt), 64'd1);
        check("ro_len", 64'(dur), 64'd1024);
`else
        for (int i = 0; i < 512; i++) exp_mw.push_back({2'd0, 32'h77, 9'(i), 8'(i) ^ 8'h3C});
        run_req(3'b000, 3'b001, 32'h77, dur);
        check("ro_done", 64'(exp_mw.size()), 64'd0);
        check("ro_err", 64'(err_cnt), 64'd0);
`endif
        img_readonly = 3'b000;

        // Reset in the middle of a drive 1 read, right after byte 200
        lat_mode = 1'b1;
        exp_lba = 32'h55; exp_drv = 2'd1; exp_we = 1'b0;
        for (int i = 0; i <= 200; i++) exp_buf.push_back({9'(i), 8'(i) ^ 8'h01});
        @(negedge clk_sys);
        sd_lba = 32'h55;
        sd_rd = 3'b010;
        wait_ack(1'b1, n);
        sd_rd = 3'b000;
        n = 0;
        while (!(sd_buff_wr === 1'b1 && sd_buff_addr === 9'd200) && n < 5000) begin
            @(negedge clk_sys);
            n++;
        end
        check("rst_point", 64'({sd_buff_wr, sd_buff_addr}), 64'({1'b1, 9'd200}));
        RESET_N = 1'b0;
        @(negedge clk_sys);
        check("rst_abort", 64'({mem.mem_req, sd_ack, busy, sd_buff_wr}), 64'd0);
        r0 = req_cnt;
        repeat (2) @(negedge clk_sys);
        RESET_N = 1'b1;
        repeat (30) @(negedge clk_sys);
        check("rst_no_resume", 64'({busy, sd_ack}), 64'd0);
        check("rst_req", 64'(req_cnt), 64'(r0));
        check("rst_buf", 64'(exp_buf.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
